viewport_sync_ctrl: RTL and testbench
=====================================

VIEWPORT_SYNC_CTRL -- requirements
Module: viewport_sync_ctrl

Interface
REQ-001 SHALL have parameter HOR_SIZE, default 800, pixels per line.
REQ-002 SHALL have parameter VER_SIZE, default 480, lines per frame.
REQ-003 SHALL have parameter HOR_PITCH, default 160, words per coarse x step.
REQ-004 SHALL have parameter ADDR_W, default 23, SDRAM word address width.
REQ-005 SHALL have parameter NUM_PAGES, default 3, frame buffers in SDRAM; PAGE_W = clog2(NUM_PAGES).
REQ-006 SHALL have parameter LINE_MODE, default 0: 0 = one read load per frame, 1 = one read load per line.
REQ-007 SHALL have parameter SYNC_POL, default 0, active level of iVS/iHS.
REQ-008 SHALL have ports iCLK (in, 1, pixel clock) and iRST (in, 1, reset); one clock; iRST is asynchronous and active-high.
REQ-009 SHALL have inputs iVS and iHS (1 each, display syncs).
REQ-010 SHALL have input iUPDATE (1): strobe that qualifies the i* view values.
REQ-011 SHALL have inputs iSCALE_FACTOR (8), iSCALE_WIDTH (10), iX_OFFSET (10), iY_OFFSET (9) and iPAGE (PAGE_W).
REQ-012 SHALL have input iBASE_ADDR (ADDR_W), static base address.
REQ-013 SHALL have outputs oSCALE_FACTOR (8), oSCALE_WIDTH (10) and oX_FINE (7), the committed view values.
REQ-014 SHALL have outputs oRD_ADDR (ADDR_W), oRD_LOAD (1, pulse), oVER_RST (1, pulse), oHOR_RST (1, pulse) and oFRAME_CNT (16).

Function
REQ-015 iVS/iHS SHALL pass through 3-flop shift registers; an edge into the active level at stages [2]->[1] SHALL produce a 1-cycle pulse on oVER_RST/oHOR_RST; latency 3 cycles from the input edge.
REQ-016 iUPDATE high SHALL capture all i* view inputs into a pending set and set a pending flag.
REQ-017 On an oVER_RST cycle with the pending flag set, the pending set SHALL commit to the active set and the flag SHALL clear.
REQ-018 If iUPDATE coincides with the commit cycle, the iUPDATE values SHALL commit directly; the pending flag SHALL end clear.
REQ-019 The active set SHALL change only on oVER_RST cycles (no tearing).
REQ-020 At commit, iY_OFFSET SHALL be clamped to VER_SIZE-1.
REQ-021 At commit, iX_OFFSET[9:7] SHALL be clamped to (HOR_SIZE/HOR_PITCH)-1.
REQ-022 At commit, iPAGE >= NUM_PAGES SHALL be replaced by NUM_PAGES-1.
REQ-023 oX_FINE SHALL equal active x_offset[6:0].
REQ-024 Frame start address SHALL be iBASE_ADDR + page*HOR_SIZE*VER_SIZE + HOR_SIZE*y_off + HOR_PITCH*x_off[9:7], truncated modulo 2^ADDR_W.
REQ-025 The frame start address SHALL be computed in a 2-stage registered pipeline.
REQ-026 oRD_LOAD SHALL pulse 3 cycles after oVER_RST, with oRD_ADDR holding the new frame start address.
REQ-027 With LINE_MODE=1, each oHOR_RST after the first in the frame SHALL add HOR_SIZE to a line pointer and pulse oRD_LOAD 1 cycle later with oRD_ADDR equal to the pointer.
REQ-028 With LINE_MODE=1, once the frame has received VER_SIZE line loads, further oHOR_RST pulses SHALL issue no oRD_LOAD until the next oVER_RST.
REQ-029 If oHOR_RST and oVER_RST coincide, the vertical event SHALL win; no line load SHALL be issued.
REQ-030 oFRAME_CNT SHALL increment on every oVER_RST and wrap from 0xFFFF to 0.
REQ-031 oRD_ADDR SHALL hold its value between loads.

Reset
REQ-032 iRST SHALL clear the sync shift registers to the inactive level, so no edge pulse occurs on release.
REQ-033 iRST SHALL set the active set to factor 0x80, width 800, x/y 0, page 0.
REQ-034 iRST SHALL clear the pending flag, oRD_ADDR, oRD_LOAD, oVER_RST, oHOR_RST and oFRAME_CNT.
REQ-035 iRST asserted mid-pipeline SHALL abort any in-flight load; no oRD_LOAD SHALL follow reset release until a new vertical edge.

Structure
REQ-036 Sync-polarity constants, reset view defaults (0x80, 800) and the view-set record type SHALL live in shared package display_pkg.
REQ-037 The edge detector SHALL be sub-module sync_edge_det (parameter SYNC_POL), instantiated twice.

Verification
REQ-038 Reset then release with iVS held inactive -> no pulses; oSCALE_FACTOR=0x80, oSCALE_WIDTH=800, oRD_ADDR=0.
REQ-039 iUPDATE y=10, x=0x185, page=1, then VS edge -> oRD_LOAD 3 cycles after oVER_RST; oRD_ADDR=384000+8000+480=392480; oX_FINE=0x05.
REQ-040 Commit clamping: iY_OFFSET=500, iX_OFFSET=0x3FF, iPAGE=3 -> committed y=479, coarse x=4, page=2.
REQ-041 iUPDATE on the exact oVER_RST cycle -> those values appear in oRD_ADDR; the pending flag ends clear.
REQ-042 LINE_MODE=1, 482 HS edges per frame -> exactly 480 oRD_LOAD pulses with addresses stepping by 800; a coincident HS/VS edge gives only the frame load.
REQ-043 oFRAME_CNT preloaded via 65535 VS edges -> wraps to 0 on the next edge; iRST asserted between oVER_RST and oRD_LOAD -> no load issued.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants, the view-set record and a saturation helper
// used by the viewport controller.
package display_pkg;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam logic [7:0] DEF_SCALE_FACTOR = 8'h80;
  localparam logic [9:0] DEF_SCALE_WIDTH  = 10'd800;

  // Wide enough for any practical page count; narrower page ports zero-extend.
  localparam int unsigned PAGE_FIELD_W = 8;

  typedef struct packed {
    logic [7:0]              scale_factor;
    logic [9:0]              scale_width;
    logic [9:0]              x_offset;
    logic [8:0]              y_offset;
    logic [PAGE_FIELD_W-1:0] page;
  } view_set_t;

  localparam view_set_t VIEW_RESET = '{
    scale_factor: DEF_SCALE_FACTOR,
    scale_width:  DEF_SCALE_WIDTH,
    x_offset:     '0,
    y_offset:     '0,
    page:         '0
  };

  function automatic int unsigned sat_max(int unsigned value, int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop sync shift register with a registered pulse on entry into
// the active level (stages [2]->[1]).
module sync_edge_det #(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic pulse
);

  logic [2:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= {3{~SYNC_POL}};
      pulse <= 1'b0;
    end else begin
      sr_q  <= {sr_q[1:0], sync_in};
      pulse <= (sr_q[1] == SYNC_POL) && (sr_q[2] != SYNC_POL);
    end
  end

endmodule

// File: rtl/viewport_sync_ctrl.sv
// Tear-free viewport controller: commits view updates on vertical sync and
// issues SDRAM read loads per frame or per line.
module viewport_sync_ctrl
  import display_pkg::*;
#(
  parameter int unsigned HOR_SIZE  = 800,
  parameter int unsigned VER_SIZE  = 480,
  parameter int unsigned HOR_PITCH = 160,
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned NUM_PAGES = 3,
  parameter int unsigned LINE_MODE = 0,
  parameter logic        SYNC_POL  = SYNC_ACTIVE_LOW,
  localparam int unsigned PAGE_W   = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVS,
  input  logic              iHS,
  input  logic              iUPDATE,
  input  logic [7:0]        iSCALE_FACTOR,
  input  logic [9:0]        iSCALE_WIDTH,
  input  logic [9:0]        iX_OFFSET,
  input  logic [8:0]        iY_OFFSET,
  input  logic [PAGE_W-1:0] iPAGE,
  input  logic [ADDR_W-1:0] iBASE_ADDR,
  output logic [7:0]        oSCALE_FACTOR,
  output logic [9:0]        oSCALE_WIDTH,
  output logic [6:0]        oX_FINE,
  output logic [ADDR_W-1:0] oRD_ADDR,
  output logic              oRD_LOAD,
  output logic              oVER_RST,
  output logic              oHOR_RST,
  output logic [15:0]       oFRAME_CNT
);

  localparam int unsigned FRAME_WORDS  = HOR_SIZE * VER_SIZE;
  localparam int unsigned X_COARSE_MAX = HOR_SIZE / HOR_PITCH - 1;
  localparam int unsigned LINE_CNT_W   = $clog2(VER_SIZE + 1);

  logic ver_pulse, hor_pulse;

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_det (
    .clk     (iCLK),
    .rst     (iRST),
    .sync_in (iVS),
    .pulse   (ver_pulse)
  );

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_det (
    .clk     (iCLK),
    .rst     (iRST),
    .sync_in (iHS),
    .pulse   (hor_pulse)
  );

  view_set_t in_set, src_set, commit_set, pend_q, active_q;
  logic      pend_flag_q, commit_en;

  always_comb begin
    in_set              = VIEW_RESET;
    in_set.scale_factor = iSCALE_FACTOR;
    in_set.scale_width  = iSCALE_WIDTH;
    in_set.x_offset     = iX_OFFSET;
    in_set.y_offset     = iY_OFFSET;
    in_set.page         = PAGE_FIELD_W'(iPAGE);

    // A same-cycle update bypasses the pending set.
    src_set   = iUPDATE ? in_set : pend_q;
    commit_en = ver_pulse && (iUPDATE || pend_flag_q);

    commit_set               = src_set;
    commit_set.y_offset      = 9'(sat_max(32'(src_set.y_offset), VER_SIZE - 1));
    commit_set.x_offset[9:7] = 3'(sat_max(32'(src_set.x_offset[9:7]), X_COARSE_MAX));
    commit_set.page          = (32'(src_set.page) >= NUM_PAGES) ?
                               PAGE_FIELD_W'(NUM_PAGES - 1) : src_set.page;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pend_q      <= VIEW_RESET;
      pend_flag_q <= 1'b0;
      active_q    <= VIEW_RESET;
    end else begin
      if (iUPDATE)   pend_q   <= in_set;
      if (commit_en) active_q <= commit_set;
      if (ver_pulse)    pend_flag_q <= 1'b0;
      else if (iUPDATE) pend_flag_q <= 1'b1;
    end
  end

  // Frame start address: terms registered one cycle after commit, summed the next.
  logic              ver_d1_q, ver_d2_q;
  logic [ADDR_W-1:0] page_term_q, line_term_q, frame_addr;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ver_d1_q    <= 1'b0;
      ver_d2_q    <= 1'b0;
      page_term_q <= '0;
      line_term_q <= '0;
    end else begin
      ver_d1_q    <= ver_pulse;
      ver_d2_q    <= ver_d1_q;
      page_term_q <= ADDR_W'(32'(active_q.page) * FRAME_WORDS);
      line_term_q <= ADDR_W'(32'(active_q.y_offset) * HOR_SIZE +
                             32'(active_q.x_offset[9:7]) * HOR_PITCH);
    end
  end

  assign frame_addr = iBASE_ADDR + page_term_q + line_term_q;

  logic [ADDR_W-1:0]     rd_addr_q, line_ptr_q;
  logic                  rd_load_q, line_seen_q, line_load;
  logic [LINE_CNT_W-1:0] line_cnt_q;
  logic [15:0]           frame_cnt_q;

  // The first HS of a frame belongs to the frame load; line_cnt_q == 0 means
  // the frame load has not landed yet, so the pointer is not valid.
  assign line_load = (LINE_MODE != 0) && hor_pulse && !ver_pulse && line_seen_q &&
                     (line_cnt_q != '0) && (line_cnt_q < LINE_CNT_W'(VER_SIZE));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_addr_q   <= '0;
      rd_load_q   <= 1'b0;
      line_ptr_q  <= '0;
      line_cnt_q  <= '0;
      line_seen_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rd_load_q <= 1'b0;
      if (ver_pulse) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        line_cnt_q  <= '0;
        line_seen_q <= 1'b0;
      end else if (hor_pulse) begin
        line_seen_q <= 1'b1;
      end
      if (ver_d2_q) begin
        rd_addr_q  <= frame_addr;
        rd_load_q  <= 1'b1;
        line_ptr_q <= frame_addr;
        line_cnt_q <= LINE_CNT_W'(1);
      end else if (line_load) begin
        rd_addr_q  <= line_ptr_q + ADDR_W'(HOR_SIZE);
        rd_load_q  <= 1'b1;
        line_ptr_q <= line_ptr_q + ADDR_W'(HOR_SIZE);
        line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);
      end
    end
  end

  assign oSCALE_FACTOR = active_q.scale_factor;
  assign oSCALE_WIDTH  = active_q.scale_width;
  assign oX_FINE       = active_q.x_offset[6:0];
  assign oRD_ADDR      = rd_addr_q;
  assign oRD_LOAD      = rd_load_q;
  assign oVER_RST      = ver_pulse;
  assign oHOR_RST      = hor_pulse;
  assign oFRAME_CNT    = frame_cnt_q;

endmodule

// File: tb/tb_viewport_sync_ctrl.sv
// Directed bench for viewport_sync_ctrl: frame-mode and line-mode instances
// share one stimulus stream.
module tb_viewport_sync_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vs, hs, upd;
  logic [7:0]  sf;
  logic [9:0]  sw, xo;
  logic [8:0]  yo;
  logic [1:0]  pg;
  logic [22:0] base;

  logic [7:0]  o0_sf, o1_sf;
  logic [9:0]  o0_sw, o1_sw;
  logic [6:0]  o0_xf, o1_xf;
  logic [22:0] o0_rd_addr, o1_rd_addr;
  logic        o0_rd_load, o1_rd_load, o0_ver, o1_ver, o0_hor, o1_hor;
  logic [15:0] o0_fcnt, o1_fcnt;

  viewport_sync_ctrl #(.LINE_MODE(0)) dut0 (
    .iCLK(clk), .iRST(rst), .iVS(vs), .iHS(hs), .iUPDATE(upd),
    .iSCALE_FACTOR(sf), .iSCALE_WIDTH(sw), .iX_OFFSET(xo), .iY_OFFSET(yo),
    .iPAGE(pg), .iBASE_ADDR(base),
    .oSCALE_FACTOR(o0_sf), .oSCALE_WIDTH(o0_sw), .oX_FINE(o0_xf),
    .oRD_ADDR(o0_rd_addr), .oRD_LOAD(o0_rd_load), .oVER_RST(o0_ver),
    .oHOR_RST(o0_hor), .oFRAME_CNT(o0_fcnt)
  );

  viewport_sync_ctrl #(.LINE_MODE(1)) dut1 (
    .iCLK(clk), .iRST(rst), .iVS(vs), .iHS(hs), .iUPDATE(upd),
    .iSCALE_FACTOR(sf), .iSCALE_WIDTH(sw), .iX_OFFSET(xo), .iY_OFFSET(yo),
    .iPAGE(pg), .iBASE_ADDR(base),
    .oSCALE_FACTOR(o1_sf), .oSCALE_WIDTH(o1_sw), .oX_FINE(o1_xf),
    .oRD_ADDR(o1_rd_addr), .oRD_LOAD(o1_rd_load), .oVER_RST(o1_ver),
    .oHOR_RST(o1_hor), .oFRAME_CNT(o1_fcnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          ld0_cnt, ld1_cnt, step_err, pulse_cnt;
  logic [22:0] ld1_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    ld0_cnt   = 0;
    ld1_cnt   = 0;
    step_err  = 0;
    pulse_cnt = 0;
    ld1_addr  = '0;
  endtask

  // Advance one cycle and sample on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (o0_rd_load) ld0_cnt++;
    if (o0_ver || o0_hor || o1_ver || o1_hor) pulse_cnt++;
    if (o1_rd_load) begin
      if (ld1_cnt > 0 && o1_rd_addr != ld1_addr + 23'd800) step_err++;
      ld1_addr = o1_rd_addr;
      ld1_cnt++;
    end
  endtask

  task automatic post_update(input logic [7:0] f, input logic [9:0] w, input logic [9:0] x,
                             input logic [8:0] y, input logic [1:0] p);
    sf = f; sw = w; xo = x; yo = y; pg = p;
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  // Drive a VS edge and return on the oVER_RST cycle (lat = cycles taken).
  task automatic vs_frame(output int lat);
    lat = -1;
    vs  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) vs = 1'b1;
      if (o0_ver) begin
        lat = i;
        break;
      end
    end
    vs = 1'b1;
  endtask

  task automatic wait_load(output int lat, output logic [22:0] addr);
    lat  = -1;
    addr = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      upd = 1'b0;
      if (o0_rd_load) begin
        lat  = i;
        addr = o0_rd_addr;
        break;
      end
    end
  endtask

  task automatic hs_pulse();
    hs = 1'b0;
    tick();
    tick();
    hs = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          lat;
  logic [22:0] addr;

  initial begin
    rst = 1'b1; vs = 1'b1; hs = 1'b1; upd = 1'b0;
    sf = '0; sw = '0; xo = '0; yo = '0; pg = '0; base = '0;
    repeat (3) tick();
    rst = 1'b0;
    clear_counts();
    repeat (6) tick();
    check("idle_pulses", pulse_cnt, 0);
    check("idle_loads", ld0_cnt + ld1_cnt, 0);
    check("rst_factor", o0_sf, 8'h80);
    check("rst_width", o0_sw, 10'd800);
    check("rst_addr", o0_rd_addr, 0);
    check("rst_fcnt", o0_fcnt, 0);

    // Basic commit: page 1, y 10, x 0x185 -> 384000 + 8000 + 480.
    post_update(8'h40, 10'd640, 10'h185, 9'd10, 2'd1);
    check("pre_commit_factor", o0_sf, 8'h80);
    vs_frame(lat);
    check("ver_latency", lat, 3);
    check("ver_cycle_factor", o0_sf, 8'h80);
    wait_load(lat, addr);
    check("load_latency", lat, 3);
    check("frame_addr", addr, 23'd392480);
    check("factor", o0_sf, 8'h40);
    check("width", o0_sw, 10'd640);
    check("x_fine", o0_xf, 7'h05);
    check("fcnt_1", o0_fcnt, 1);

    // Clamping: y 500 -> 479, coarse x 7 -> 4, page 3 -> 2.
    post_update(8'h40, 10'd640, 10'h3FF, 9'd500, 2'd3);
    vs_frame(lat);
    wait_load(lat, addr);
    check("clamp_addr", addr, 23'd1151840);
    check("clamp_x_fine", o0_xf, 7'h7F);
    check("fcnt_2", o0_fcnt, 2);

    // Update landing on the oVER_RST cycle overrides the pending set.
    base = 23'd1000;
    post_update(8'h11, 10'd800, 10'h000, 9'd2, 2'd2);
    vs_frame(lat);
    sf = 8'h22; sw = 10'd800; xo = 10'h080; yo = 9'd1; pg = 2'd0;
    upd = 1'b1;
    wait_load(lat, addr);
    check("same_cycle_latency", lat, 3);
    check("same_cycle_addr", addr, 23'd1960);
    check("same_cycle_factor", o0_sf, 8'h22);
    check("pending_clear", dut0.pend_flag_q, 0);
    vs_frame(lat);
    wait_load(lat, addr);
    check("no_stale_commit", addr, 23'd1960);

    // Line mode: frame at address 0, then a coincident HS/VS mid-frame.
    base = '0;
    post_update(8'h80, 10'd800, 10'h000, 9'd0, 2'd0);
    vs_frame(lat);
    wait_load(lat, addr);
    repeat (3) hs_pulse();
    clear_counts();
    vs = 1'b0; hs = 1'b0;
    tick();
    tick();
    vs = 1'b1; hs = 1'b1;
    repeat (10) tick();
    check("coincident_loads", ld1_cnt, 1);
    check("coincident_addr", ld1_addr, 0);
    repeat (482) hs_pulse();
    repeat (4) tick();
    check("line_load_count", ld1_cnt, 480);
    check("line_last_addr", ld1_addr, 23'd383200);
    check("line_step", step_err, 0);
    check("frame_mode_loads", ld0_cnt, 1);

    // Reset between oVER_RST and oRD_LOAD aborts the load.
    vs_frame(lat);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_counts();
    repeat (12) tick();
    check("abort_loads", ld0_cnt + ld1_cnt, 0);
    check("abort_fcnt", o0_fcnt, 0);
    check("abort_addr", o0_rd_addr, 0);
    check("abort_factor", o0_sf, 8'h80);

    // Frame counter wrap from a preloaded 0xFFFF.
    force dut0.frame_cnt_q = 16'hFFFF;
    tick();
    release dut0.frame_cnt_q;
    tick();
    check("fcnt_preload", o0_fcnt, 16'hFFFF);
    vs_frame(lat);
    tick();
    check("fcnt_wrap", o0_fcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
